// File: rtl/apb_mem_slave.sv
//==============================================================================
// Module      : apb_mem_slave
// Description : APB slave fronting a DEPTH x DATA_W memory with byte strobes,
//               PSLVERR decode and none/fixed/LFSR-random wait states.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_mem_slave #(
    parameter int         ADDR_W    = 10,
    parameter int         DATA_W    = 32,
    parameter int         DEPTH     = 16,
    parameter int         WAIT_MODE = 0,
    parameter int         WAIT_CYC  = 2,
    parameter logic [3:0] LFSR_SEED = 4'hE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic [ADDR_W-1:0]     paddr_i,
    input  logic                  pwrite_i,
    input  logic [DATA_W-1:0]     pwdata_i,
    input  logic [DATA_W/8-1:0]   pstrb_i,
    output logic [DATA_W-1:0]     prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o
);

    localparam int c_NB     = DATA_W / 8;
    localparam int c_OFF_W  = $clog2(c_NB);
    localparam int c_IDX_W  = ADDR_W - c_OFF_W;
    localparam int c_MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_IDX_W:0] c_DEPTH = (c_IDX_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_lfsr;
    logic [3:0]          r_wait_cnt;
    logic [3:0]          w_wait_ld;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [c_NB-1:0]     r_strb;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_setup;
    logic                w_done;
    logic                w_err;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_MEM_AW-1:0] w_widx;

    assign w_setup = psel_i & ~penable_i;
    // Completion is suppressed while reset is high so an in-flight write is dropped.
    assign w_done  = ~reset & (r_state == ST_ACCESS) & psel_i & penable_i
                   & (r_wait_cnt == 4'd0);
    assign w_idx   = r_addr[ADDR_W-1:c_OFF_W];
    assign w_widx  = w_idx[c_MEM_AW-1:0];
    assign w_err   = ({1'b0, w_idx} >= c_DEPTH) | (r_addr[c_OFF_W-1:0] != '0);

    always_comb begin
        w_wait_ld = 4'd0;
        if (WAIT_MODE == 1) begin
            w_wait_ld = 4'(WAIT_CYC);
        end else if (WAIT_MODE == 2) begin
            w_wait_ld = {1'b0, r_lfsr[2:0]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!psel_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (penable_i && (r_wait_cnt == 4'd0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_lfsr     <= LFSR_SEED;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
            if ((r_state == ST_IDLE) && w_setup) begin
                r_wait_cnt <= w_wait_ld;
            end else if ((r_state == ST_ACCESS) && psel_i && penable_i
                         && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && w_setup) begin
            r_addr  <= paddr_i;
            r_write <= pwrite_i;
            r_strb  <= pstrb_i;
            r_wdata <= pwdata_i;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NB; i++) begin
            if (w_done && r_write && !w_err && r_strb[i]) begin
                r_mem[w_widx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign pready_o  = w_done;
    assign pslverr_o = w_done & w_err;
    assign prdata_o  = (w_done && !r_write && !w_err) ? r_mem[w_widx] : '0;

endmodule

`default_nettype wire
